// File: rtl/cv32e40p_ft_redundancy_ctrl.sv
// Degradation controller for the triple-replicated cv32e40p pipeline: TMR -> DMR -> SIMPLEX -> FAIL,
// with DMR rollback handshake. Define CV32E40P_FT_SIMPLEX_EN to compile the SIMPLEX state.
module cv32e40p_ft_redundancy_ctrl #(
   parameter int ACK_TIMEOUT  = 16,
   parameter int MAX_RETRY    = 2,
   parameter int CLEAN_WINDOW = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] is_broken_i,
   input  logic [2:0] err_detected_i,
   input  logic       restart_ack_i,
   output logic [2:0] set_broken_o,
   output logic [2:0] active_mask_o,
   output logic [1:0] mode_o,
   output logic       restart_req_o,
   output logic       fatal_o
);

   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
   localparam int RT_W = $clog2(MAX_RETRY + 1);
   localparam int CL_W = $clog2(CLEAN_WINDOW + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
   localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);
   localparam logic [CL_W-1:0] CL_LAST = CL_W'(CLEAN_WINDOW - 1);

   typedef enum logic [2:0] {
      S_TMR, S_DMR, S_RESTART, S_FAIL
`ifdef CV32E40P_FT_SIMPLEX_EN
      , S_SIMPLEX
`endif
   } state_e;

`ifdef CV32E40P_FT_SIMPLEX_EN
   localparam state_e L_DEGRADE = S_SIMPLEX;
`else
   localparam state_e L_DEGRADE = S_FAIL;
`endif

   state_e          r_state, w_state_nxt;
   logic [2:0]      r_broken, w_broken_in, w_broken_nxt, w_active, w_force, r_set_broken;
   logic [1:0]      w_nbroken;
   logic            w_mism;
   logic [TO_W-1:0] r_to, w_to_nxt;
   logic [RT_W-1:0] r_retry, w_retry_nxt;
   logic [CL_W-1:0] r_clean, w_clean_nxt;

   function automatic logic [1:0] f_popcnt(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

   function automatic logic [2:0] f_hi_active(input logic [2:0] a);
      if (a[2])      return 3'b100;
      else if (a[1]) return 3'b010;
      else if (a[0]) return 3'b001;
      else           return 3'b000;
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_force     = 3'b000;
      w_to_nxt    = r_to;
      w_retry_nxt = r_retry;
      w_clean_nxt = r_clean;
      w_active    = ~r_broken;
      w_broken_in = r_broken | is_broken_i;
      w_nbroken   = f_popcnt(w_broken_in);
      w_mism      = |(err_detected_i & w_active);
      case (r_state)
         S_TMR: begin
            case (w_nbroken)
               2'd1:    w_state_nxt = S_DMR;
               2'd2:    w_state_nxt = L_DEGRADE;
               2'd3:    w_state_nxt = S_FAIL;
               default: w_state_nxt = S_TMR;
            endcase
         end
         S_DMR: begin
            // Breakage has priority: a mismatch in the same cycle never triggers a restart.
            if (w_nbroken == 2'd3) begin
               w_state_nxt = S_FAIL;
            end else if (w_nbroken == 2'd2) begin
               w_state_nxt = L_DEGRADE;
            end else if (w_mism) begin
               w_clean_nxt = '0;
               if (r_retry < RT_MAX) begin
                  w_retry_nxt = r_retry + 1'b1;
                  w_to_nxt    = '0;
                  w_state_nxt = S_RESTART;
               end else begin
                  w_force     = f_hi_active(w_active);
                  w_retry_nxt = '0;
                  w_state_nxt = L_DEGRADE;
               end
            end else if (r_clean >= CL_LAST) begin
               w_clean_nxt = '0;
               w_retry_nxt = '0;
            end else begin
               w_clean_nxt = r_clean + 1'b1;
            end
         end
         S_RESTART: begin
            if (restart_ack_i) begin
               w_to_nxt    = '0;
               w_state_nxt = S_DMR;
            end else if (r_to >= TO_LAST) begin
               w_state_nxt = S_FAIL;
            end else begin
               w_to_nxt = r_to + 1'b1;
            end
         end
`ifdef CV32E40P_FT_SIMPLEX_EN
         S_SIMPLEX: begin
            if (w_nbroken == 2'd3) w_state_nxt = S_FAIL;
         end
`endif
         S_FAIL:  w_state_nxt = S_FAIL;
         default: w_state_nxt = S_FAIL;
      endcase
      w_broken_nxt = w_broken_in | w_force;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_TMR;
         r_broken     <= 3'b000;
         r_set_broken <= 3'b000;
         r_to         <= '0;
         r_retry      <= '0;
         r_clean      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_broken     <= w_broken_nxt;
         r_set_broken <= w_force;
         r_to         <= w_to_nxt;
         r_retry      <= w_retry_nxt;
         r_clean      <= w_clean_nxt;
      end
   end

   always_comb begin
      case (r_state)
         S_TMR:     mode_o = 2'd0;
         S_DMR:     mode_o = 2'd1;
         S_RESTART: mode_o = 2'd1;
`ifdef CV32E40P_FT_SIMPLEX_EN
         S_SIMPLEX: mode_o = 2'd2;
`endif
         default:   mode_o = 2'd3;
      endcase
   end

   assign fatal_o       = (r_state == S_FAIL);
   assign restart_req_o = (r_state == S_RESTART);
   assign active_mask_o = fatal_o ? 3'b000 : ~r_broken;
   assign set_broken_o  = r_set_broken;

endmodule

// File: tb/tb_cv32e40p_ft_redundancy_ctrl.sv
// Directed bench for cv32e40p_ft_redundancy_ctrl: vector table plus multi-cycle sequences
// (ack timeout, ack/timeout tie, clean window). Honours CV32E40P_FT_SIMPLEX_EN.
module tb_cv32e40p_ft_redundancy_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] is_broken_i;
   logic [2:0] err_detected_i;
   logic       restart_ack_i;
   logic [2:0] set_broken_o;
   logic [2:0] active_mask_o;
   logic [1:0] mode_o;
   logic       restart_req_o;
   logic       fatal_o;

   int n_checks = 0;
   int n_errors = 0;

`ifdef CV32E40P_FT_SIMPLEX_EN
   localparam bit SIMPLEX = 1'b1;
`else
   localparam bit SIMPLEX = 1'b0;
`endif
   localparam logic [1:0] DM = SIMPLEX ? 2'd2 : 2'd3;
   localparam logic       DF = !SIMPLEX;

   cv32e40p_ft_redundancy_ctrl #(
      .ACK_TIMEOUT(16), .MAX_RETRY(2), .CLEAN_WINDOW(64)
   ) dut (
      .clk(clk), .rst(rst),
      .is_broken_i(is_broken_i), .err_detected_i(err_detected_i), .restart_ack_i(restart_ack_i),
      .set_broken_o(set_broken_o), .active_mask_o(active_mask_o), .mode_o(mode_o),
      .restart_req_o(restart_req_o), .fatal_o(fatal_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [2:0] brk;
      logic [2:0] err;
      logic       ack;
      logic [2:0] sb;
      logic [2:0] mask;
      logic [1:0] mode;
      logic       req;
      logic       fatal;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [2:0] dg(input logic [2:0] m);
      return SIMPLEX ? m : 3'b000;
   endfunction

   function automatic vec_t mk(input logic r, input logic [2:0] b, input logic [2:0] e, input logic a,
                               input logic [2:0] sb, input logic [2:0] m, input logic [1:0] md,
                               input logic rq, input logic f);
      vec_t v;
      v.rst = r; v.brk = b; v.err = e; v.ack = a;
      v.sb = sb; v.mask = m; v.mode = md; v.req = rq; v.fatal = f;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [2:0] b, input logic [2:0] e, input logic a);
      rst = r; is_broken_i = b; err_detected_i = e; restart_ack_i = a;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [2:0] sb, input logic [2:0] m,
                             input logic [1:0] md, input logic rq, input logic f);
      chk({tag, ".set_broken"}, {5'd0, set_broken_o}, {5'd0, sb});
      chk({tag, ".mask"}, {5'd0, active_mask_o}, {5'd0, m});
      chk({tag, ".mode"}, {6'd0, mode_o}, {6'd0, md});
      chk({tag, ".req"}, {7'd0, restart_req_o}, {7'd0, rq});
      chk({tag, ".fatal"}, {7'd0, fatal_o}, {7'd0, f});
   endtask

   initial begin
      rst = 1'b1; is_broken_i = 3'b000; err_detected_i = 3'b000; restart_ack_i = 1'b0;

      // TMR -> DMR -> degrade; err ignored in TMR
      vecs.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 3'b111, 2'd0, 0, 0));
      vecs.push_back(mk(0, 3'b000, 3'b111, 0, 3'b000, 3'b111, 2'd0, 0, 0));
      vecs.push_back(mk(0, 3'b010, 3'b000, 0, 3'b000, 3'b101, 2'd1, 0, 0));
      vecs.push_back(mk(0, 3'b011, 3'b000, 0, 3'b000, dg(3'b100), DM, 0, DF));
      vecs.push_back(mk(0, 3'b011, 3'b000, 0, 3'b000, dg(3'b100), DM, 0, DF));
      vecs.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 3'b111, 2'd0, 0, 0));
      // restart handshake x2, third error forces breakage of replica 1
      vecs.push_back(mk(0, 3'b100, 3'b000, 0, 3'b000, 3'b011, 2'd1, 0, 0));
      vecs.push_back(mk(0, 3'b100, 3'b001, 0, 3'b000, 3'b011, 2'd1, 1, 0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0, 3'b100, 3'b000, 0, 3'b000, 3'b011, 2'd1, 1, 0));
      vecs.push_back(mk(0, 3'b100, 3'b000, 1, 3'b000, 3'b011, 2'd1, 0, 0));
      vecs.push_back(mk(0, 3'b100, 3'b010, 0, 3'b000, 3'b011, 2'd1, 1, 0));
      vecs.push_back(mk(0, 3'b100, 3'b000, 1, 3'b000, 3'b011, 2'd1, 0, 0));
      vecs.push_back(mk(0, 3'b100, 3'b001, 0, 3'b010, dg(3'b001), DM, 0, DF));
      vecs.push_back(mk(0, 3'b100, 3'b000, 0, 3'b000, dg(3'b001), DM, 0, DF));
      vecs.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 3'b111, 2'd0, 0, 0));
      // inactive-replica error and stray ack ignored; breakage beats mismatch; last replica breaks
      vecs.push_back(mk(0, 3'b100, 3'b000, 0, 3'b000, 3'b011, 2'd1, 0, 0));
      vecs.push_back(mk(0, 3'b100, 3'b100, 1, 3'b000, 3'b011, 2'd1, 0, 0));
      vecs.push_back(mk(0, 3'b110, 3'b001, 0, 3'b000, dg(3'b001), DM, 0, DF));
      vecs.push_back(mk(0, 3'b111, 3'b000, 0, 3'b000, 3'b000, 2'd3, 0, 1));
      vecs.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 3'b111, 2'd0, 0, 0));
      // double and triple breakage straight from TMR
      vecs.push_back(mk(0, 3'b110, 3'b000, 0, 3'b000, dg(3'b001), DM, 0, DF));
      vecs.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 3'b111, 2'd0, 0, 0));
      vecs.push_back(mk(0, 3'b111, 3'b000, 0, 3'b000, 3'b000, 2'd3, 0, 1));
      vecs.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 3'b111, 2'd0, 0, 0));
      // reset while restart_req is high: dropped at that edge, no ack needed
      vecs.push_back(mk(0, 3'b100, 3'b000, 0, 3'b000, 3'b011, 2'd1, 0, 0));
      vecs.push_back(mk(0, 3'b100, 3'b010, 0, 3'b000, 3'b011, 2'd1, 1, 0));
      vecs.push_back(mk(1, 3'b100, 3'b000, 0, 3'b000, 3'b111, 2'd0, 0, 0));
      vecs.push_back(mk(0, 3'b100, 3'b000, 0, 3'b000, 3'b011, 2'd1, 0, 0));
      vecs.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 3'b111, 2'd0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].brk, vecs[i].err, vecs[i].ack);
         expect_out($sformatf("vec%0d", i), vecs[i].sb, vecs[i].mask, vecs[i].mode,
                    vecs[i].req, vecs[i].fatal);
      end

      // ack timeout: request held 16 cycles then FAIL, sticky until reset
      step(0, 3'b100, 3'b000, 0);
      step(0, 3'b100, 3'b001, 0);
      expect_out("to.enter", 3'b000, 3'b011, 2'd1, 1, 0);
      for (int i = 1; i <= 15; i++) begin
         step(0, 3'b100, 3'b000, 0);
         expect_out($sformatf("to.wait%0d", i), 3'b000, 3'b011, 2'd1, 1, 0);
      end
      step(0, 3'b100, 3'b000, 0);
      expect_out("to.fail", 3'b000, 3'b000, 2'd3, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 3'b000, 3'b011, 1);
         expect_out($sformatf("to.sticky%0d", i), 3'b000, 3'b000, 2'd3, 0, 1);
      end
      step(1, 3'b000, 3'b000, 0);
      expect_out("to.rst", 3'b000, 3'b111, 2'd0, 0, 0);

      // ack arriving on the timeout cycle wins
      step(0, 3'b100, 3'b000, 0);
      step(0, 3'b100, 3'b001, 0);
      for (int i = 1; i <= 15; i++) step(0, 3'b100, 3'b000, 0);
      expect_out("tie.pre", 3'b000, 3'b011, 2'd1, 1, 0);
      step(0, 3'b100, 3'b000, 1);
      expect_out("tie.ack", 3'b000, 3'b011, 2'd1, 0, 0);
      step(1, 3'b000, 3'b000, 0);

      // 64 clean cycles clear the retry count; 63 do not
      for (int w = 64; w >= 63; w--) begin
         step(0, 3'b100, 3'b000, 0);
         step(0, 3'b100, 3'b001, 0);
         expect_out($sformatf("cw%0d.r1", w), 3'b000, 3'b011, 2'd1, 1, 0);
         step(0, 3'b100, 3'b000, 1);
         for (int i = 0; i < w; i++) step(0, 3'b100, 3'b000, 0);
         expect_out($sformatf("cw%0d.clean", w), 3'b000, 3'b011, 2'd1, 0, 0);
         step(0, 3'b100, 3'b001, 0);
         expect_out($sformatf("cw%0d.r2", w), 3'b000, 3'b011, 2'd1, 1, 0);
         step(0, 3'b100, 3'b000, 1);
         step(0, 3'b100, 3'b001, 0);
         if (w == 64) begin
            expect_out("cw64.r3", 3'b000, 3'b011, 2'd1, 1, 0);
            step(0, 3'b100, 3'b000, 1);
            step(0, 3'b100, 3'b001, 0);
         end
         expect_out($sformatf("cw%0d.force", w), 3'b010, dg(3'b001), DM, 0, DF);
         step(0, 3'b100, 3'b000, 0);
         expect_out($sformatf("cw%0d.pulse", w), 3'b000, dg(3'b001), DM, 0, DF);
         step(1, 3'b000, 3'b000, 0);
         expect_out($sformatf("cw%0d.rst", w), 3'b000, 3'b111, 2'd0, 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cv32e40p_ft_redundancy_ctrl.md
# cv32e40p_ft_redundancy_ctrl

Degradation controller for the triple-replicated cv32e40p fault-tolerant pipeline. It watches the per-replica breakage flags and voter disagreement flags, and selects the active replica set: TMR, then DMR, then SIMPLEX, then FAIL. In DMR it sequences a restart (rollback) handshake with the core and escalates repeated unlocalisable mismatches into a forced breakage. It sits between the three breakage monitors / voter and the core's replica-select and restart logic.

## Interface
- `ACK_TIMEOUT`, 16: max cycles `restart_req_o` may stay high without `restart_ack_i`.
- `MAX_RETRY`, 2: consecutive DMR restarts tolerated before forcing a breakage.
- `CLEAN_WINDOW`, 64: error-free DMR cycles that clear the retry count.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `is_broken_i`  in  3  per-replica breakage flag from the monitors (sticky at source).
- `err_detected_i`  in  3  per-replica voter disagreement flag, valid every cycle.
- `restart_ack_i`  in  1  core has completed rollback.
- `set_broken_o`  out  3  one-cycle pulse forcing a monitor to broken.
- `active_mask_o`  out  3  replicas currently used by the voter.
- `mode_o`  out  2  encoding: 0 TMR, 1 DMR, 2 SIMPLEX, 3 FAIL.
- `restart_req_o`  out  1  rollback request.
- `fatal_o`  out  1  sticky unrecoverable failure.

## Operation
- Internal `broken_q[2:0]` is set by `is_broken_i` OR by the controller's own `set_broken_o`. It is cleared only by reset. `active_mask_o = ~broken_q` while the block is not in FAIL.
- FSM states: TMR, DMR, RESTART, SIMPLEX, FAIL.
- **TMR**
  - `err_detected_i` is ignored, because the voter masks it.
  - Next state follows popcount(`broken_q`) after the update: 1 → DMR, 2 → SIMPLEX, 3 → FAIL.
- **DMR**
  - If an active replica breaks, go to SIMPLEX, or to FAIL if both break.
  - Otherwise, `err_detected_i` on any active replica means an unlocalisable mismatch:
    - If `retry_cnt` < `MAX_RETRY`: increment it and go to RESTART.
    - Otherwise: pulse `set_broken_o` on the higher-index active replica, clear `retry_cnt`, and go to SIMPLEX.
  - `clean_cnt` increments on each error-free DMR cycle. On reaching `CLEAN_WINDOW` it clears `retry_cnt` and itself. Any error clears `clean_cnt`.
- **RESTART**
  - `restart_req_o` = 1 and `to_cnt` increments each cycle.
  - `restart_ack_i` high → deassert the request and return to DMR.
  - `to_cnt` reaches `ACK_TIMEOUT` first → FAIL.
  - `is_broken_i` changes are captured into `broken_q` but are evaluated only after returning to DMR.
- **SIMPLEX**: `err_detected_i` is ignored. Breakage of the remaining replica → FAIL.
- **FAIL**
  - `fatal_o` = 1 and `active_mask_o` = 000.
  - Absorbing until reset.
- Counter widths are `$clog2(param+1)`. Counters saturate and never wrap.

## Timing
- All outputs are registered. Input sampled at edge k → state and outputs change at edge k+1.
- Reset values: `mode_o`=0, `active_mask_o`=111, `set_broken_o`=000, `restart_req_o`=0, `fatal_o`=0. All counters are 0.
- Reset asserted mid-RESTART drops `restart_req_o` at that same edge, with no ack required.
- `restart_ack_i` is sampled only while `restart_req_o`=1 and is ignored otherwise.
- Ack and timeout in the same cycle: ack wins.
- Same-cycle priority in DMR: breakage beats mismatch. No restart is issued for that cycle.
- `set_broken_o` is exactly one cycle wide and coincides with the transition to SIMPLEX.

## Configuration
- `CV32E40P_FT_SIMPLEX_EN`
  - Defined: behaviour is as above, and the block degrades to SIMPLEX.
  - Undefined: the SIMPLEX state is not compiled. Every transition that would enter SIMPLEX enters FAIL instead, including the forced-breakage path, which still pulses `set_broken_o`.

## Test plan
- Reset, then `is_broken_i`=010 → next cycle `mode_o`=1, `active_mask_o`=101. Then `is_broken_i`=011 → `mode_o`=2, `active_mask_o`=100.
- DMR (mask 011), `err_detected_i`=001 → `restart_req_o`=1. Ack after 5 cycles → `restart_req_o`=0 and `mode_o`=1. Repeat twice more: the third error pulses `set_broken_o`=010 and gives `mode_o`=2.
- DMR error then 64 clean cycles → `retry_cnt` cleared. The next two errors each cause only a restart.
- RESTART with no ack for 16 cycles → `mode_o`=3, `fatal_o`=1, `active_mask_o`=000, sticky until `rst`.
- DMR with breakage and error in the same cycle → SIMPLEX and no `restart_req_o`. With `CV32E40P_FT_SIMPLEX_EN` undefined → FAIL.
- `rst` asserted while `restart_req_o`=1 → all outputs return to reset values at that edge.
